pwm_compare: RTL and testbench

- Downstream consumer of the 8-bit free-running up counter's count bus.
- Compares the count against a double-buffered duty value and produces a registered PWM output plus a period-start strobe.
- New duty values arrive over a valid/ready handshake and take effect only at a period boundary (count wrap), so the output never glitches mid-period.

---
 rtl/pwm_compare.sv | 75 +++++++
 tb/tb_pwm_compare.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_compare.sv
// PWM comparator fed by a free-running up counter. It double-buffers the duty value
// and registers both the PWM output and a period-start strobe.
module pwm_compare #(
   parameter int unsigned      WIDTH        = 8,
   parameter logic [WIDTH-1:0] DEFAULT_DUTY = '0,
   parameter bit               INVERT       = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] count,
   input  logic             pwm_en,
   input  logic [WIDTH-1:0] duty_data,
   input  logic             duty_valid,
   output logic             duty_ready,
   output logic             pwm_out,
   output logic             period_start
);

   logic [WIDTH-1:0] count_prev;
   logic [WIDTH-1:0] active_duty;
   logic [WIDTH-1:0] shadow;
   logic             pending;
   logic             wrap;
   logic             accept;
   logic             apply;
   logic [WIDTH-1:0] eff_duty;
   logic             pwm_next;

   // Handshake: a transfer happens on any rising clk edge where duty_valid && duty_ready.
   // duty_ready depends only on the pending register. The sender holds duty_data
   // stable until the transfer completes.
   assign duty_ready = !pending;
   assign accept     = duty_valid && duty_ready;

   // A wrap is a falling edge into zero. A counter parked at 0 therefore gives only one wrap.
   assign wrap     = (count == '0) && (count_prev != '0);
   assign apply    = wrap && pending;
   assign eff_duty = apply ? shadow : active_duty;

   always_comb begin
      pwm_next = 1'b0;
      if (pwm_en) begin
         pwm_next = (count < eff_duty);
      end
      pwm_next = pwm_next ^ INVERT;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_prev   <= '0;
         period_start <= 1'b0;
         pwm_out      <= INVERT;
      end else begin
         count_prev   <= count;
         period_start <= wrap;
         pwm_out      <= pwm_next;
      end
   end

   // accept needs pending=0 and apply needs pending=1, so the two never coincide.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         active_duty <= DEFAULT_DUTY;
         shadow      <= '0;
         pending     <= 1'b0;
      end else if (apply) begin
         active_duty <= shadow;
         pending     <= 1'b0;
      end else if (accept) begin
         shadow      <= duty_data;
         pending     <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pwm_compare.sv
// Directed bench for pwm_compare. It drives a normal instance and an inverted instance
// from the same stimulus.
module tb_pwm_compare;

   logic       clk;
   logic       rst;
   logic [7:0] count;
   logic       pwm_en;
   logic [7:0] duty_data;
   logic       duty_valid;
   logic       duty_ready;
   logic       pwm_out;
   logic       period_start;
   logic       duty_ready_inv;
   logic       pwm_out_inv;
   logic       period_start_inv;

   int total;
   int bad;

   pwm_compare #(.WIDTH(8), .DEFAULT_DUTY(8'd0), .INVERT(1'b0)) dut (
      .clk          (clk),
      .rst          (rst),
      .count        (count),
      .pwm_en       (pwm_en),
      .duty_data    (duty_data),
      .duty_valid   (duty_valid),
      .duty_ready   (duty_ready),
      .pwm_out      (pwm_out),
      .period_start (period_start)
   );

   pwm_compare #(.WIDTH(8), .DEFAULT_DUTY(8'd0), .INVERT(1'b1)) dut_inv (
      .clk          (clk),
      .rst          (rst),
      .count        (count),
      .pwm_en       (pwm_en),
      .duty_data    (duty_data),
      .duty_valid   (duty_valid),
      .duty_ready   (duty_ready_inv),
      .pwm_out      (pwm_out_inv),
      .period_start (period_start_inv)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Check both instances against the expected non-inverted PWM level.
   task automatic chk_pwm(input logic exp, input string tag, input int c);
      total++;
      if (pwm_out !== exp) begin
         bad++;
         $display("FAIL %s pwm_out count=%0d got=%b exp=%b", tag, c, pwm_out, exp);
      end
      total++;
      if (pwm_out_inv !== ~exp) begin
         bad++;
         $display("FAIL %s pwm_out_inv count=%0d got=%b exp=%b", tag, c, pwm_out_inv, ~exp);
      end
   endtask

   // One full 0..255 period starting from a count of 255. The caller can offer one duty value at send_at.
   task automatic run_period(input int exp_duty, input int send_at, input int send_val,
                             input string tag);
      int highs;
      int pulses;
      logic e;
      highs  = 0;
      pulses = 0;
      for (int c = 0; c < 256; c++) begin
         count = 8'(c);
         if (c == send_at) begin
            duty_valid = 1'b1;
            duty_data  = 8'(send_val);
            total++;
            if (duty_ready !== 1'b1) begin
               bad++;
               $display("FAIL %s ready_before_send got=%b exp=1", tag, duty_ready);
            end
         end
         step();
         duty_valid = 1'b0;
         e = (c < exp_duty);
         chk_pwm(e, tag, c);
         if (pwm_out === 1'b1) highs++;
         if (period_start === 1'b1) pulses++;
         if (c == 0) begin
            total++;
            if (period_start !== 1'b1) begin
               bad++;
               $display("FAIL %s period_start_at_0 got=%b exp=1", tag, period_start);
            end
         end
         if (c == send_at) begin
            total++;
            if (duty_ready !== 1'b0) begin
               bad++;
               $display("FAIL %s ready_after_send got=%b exp=0", tag, duty_ready);
            end
         end
      end
      total++;
      if (highs != exp_duty) begin
         bad++;
         $display("FAIL %s high_cycles got=%0d exp=%0d", tag, highs, exp_duty);
      end
      total++;
      if (pulses != 1) begin
         bad++;
         $display("FAIL %s period_pulses got=%0d exp=1", tag, pulses);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         count      = 8'($urandom_range(0, 255));
         duty_data  = 8'($urandom_range(0, 255));
         duty_valid = 1'($urandom_range(0, 1));
         pwm_en     = 1'($urandom_range(0, 1));
         step();
         chk_pwm(1'b0, "reset_hold", i);
         total++;
         if (duty_ready !== 1'b1 || period_start !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold ready/pstart got=%b/%b exp=1/0", duty_ready, period_start);
         end
      end
      duty_valid = 1'b0;
      pwm_en     = 1'b1;
      count      = 8'd0;
      rst        = 1'b1;
      for (int c = 0; c < 256; c++) begin
         count = 8'(c);
         step();
         chk_pwm(1'b0, "reset_sweep", c);
         total++;
         if (period_start !== 1'b0) begin
            bad++;
            $display("FAIL reset_sweep period_start count=%0d got=%b exp=0", c, period_start);
         end
      end
   endtask

   task automatic test_duty_load();
      run_period(0, 10, 64, "load_old");
      run_period(64, -1, 0, "load_new");
      total++;
      if (duty_ready !== 1'b1) begin
         bad++;
         $display("FAIL load_new ready_restored got=%b exp=1", duty_ready);
      end
   endtask

   task automatic test_boundaries();
      run_period(64, 5, 0, "bound_pre");
      run_period(0, 5, 255, "bound_duty0");
      run_period(255, 5, 1, "bound_duty255");
      run_period(1, -1, 0, "bound_duty1");
   endtask

   task automatic test_wrap_collision();
      logic e;
      // accepted in the wrap cycle itself, so duty 1 still governs this period
      run_period(1, 0, 128, "collide_old");
      for (int c = 0; c < 256; c++) begin
         count = 8'(c);
         if (c == 0) begin
            duty_valid = 1'b1;
            duty_data  = 8'd200;
            total++;
            if (duty_ready !== 1'b0) begin
               bad++;
               $display("FAIL collide_held ready got=%b exp=0", duty_ready);
            end
         end
         step();
         if (c == 0) begin
            total++;
            if (duty_ready !== 1'b1) begin
               bad++;
               $display("FAIL collide_apply ready got=%b exp=1", duty_ready);
            end
         end
         if (c == 1) begin
            duty_valid = 1'b0;
            total++;
            if (duty_ready !== 1'b0) begin
               bad++;
               $display("FAIL collide_second_accept ready got=%b exp=0", duty_ready);
            end
         end
         e = (c < 128);
         chk_pwm(e, "collide_128", c);
      end
      run_period(200, -1, 0, "collide_200");
   endtask

   task automatic test_counter_reset();
      logic e;
      for (int c = 0; c <= 100; c++) begin
         count = 8'(c);
         if (c == 20) begin
            duty_valid = 1'b1;
            duty_data  = 8'd30;
         end
         step();
         duty_valid = 1'b0;
         e = (c < 200);
         chk_pwm(e, "sync_pre", c);
         total++;
         if (period_start !== (c == 0)) begin
            bad++;
            $display("FAIL sync_pre period_start count=%0d got=%b exp=%b", c, period_start, c == 0);
         end
      end
      count = 8'd0;
      step();
      chk_pwm(1'b1, "sync_wrap", 0);
      total++;
      if (period_start !== 1'b1 || duty_ready !== 1'b1) begin
         bad++;
         $display("FAIL sync_wrap pstart/ready got=%b/%b exp=1/1", period_start, duty_ready);
      end
      for (int i = 0; i < 20; i++) begin
         step();
         chk_pwm(1'b1, "stall_zero", i);
         total++;
         if (period_start !== 1'b0) begin
            bad++;
            $display("FAIL stall_zero period_start cycle=%0d got=%b exp=0", i, period_start);
         end
      end
   endtask

   task automatic test_async_reset();
      logic e;
      for (int c = 1; c < 120; c++) begin
         count = 8'(c);
         if (c == 40) begin
            duty_valid = 1'b1;
            duty_data  = 8'd90;
         end
         step();
         duty_valid = 1'b0;
         e = (c < 30);
         chk_pwm(e, "mid_duty30", c);
      end
      total++;
      if (duty_ready !== 1'b0) begin
         bad++;
         $display("FAIL mid_pending ready got=%b exp=0", duty_ready);
      end
      rst = 1'b0;
      #1;
      chk_pwm(1'b0, "async_rst", 119);
      total++;
      if (duty_ready !== 1'b1 || period_start !== 1'b0) begin
         bad++;
         $display("FAIL async_rst ready/pstart got=%b/%b exp=1/0", duty_ready, period_start);
      end
      step();
      rst   = 1'b1;
      count = 8'd0;
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if (period_start !== 1'b0) begin
            bad++;
            $display("FAIL post_rst_zero period_start cycle=%0d got=%b exp=0", i, period_start);
         end
      end
      for (int c = 1; c < 256; c++) begin
         count = 8'(c);
         step();
         chk_pwm(1'b0, "post_rst", c);
      end
      // a surviving pending value of 90 would produce high cycles here
      run_period(0, -1, 0, "post_rst_discard");
   endtask

   task automatic test_enable();
      logic e;
      run_period(0, 10, 100, "en_load");
      for (int c = 0; c < 256; c++) begin
         count  = 8'(c);
         pwm_en = (c >= 50);
         if (c == 20) begin
            duty_valid = 1'b1;
            duty_data  = 8'd10;
         end
         step();
         duty_valid = 1'b0;
         e = (c >= 50) && (c < 100);
         chk_pwm(e, "en_gate", c);
         total++;
         if (period_start !== (c == 0)) begin
            bad++;
            $display("FAIL en_gate period_start count=%0d got=%b exp=%b", c, period_start, c == 0);
         end
      end
      pwm_en = 1'b1;
      run_period(10, -1, 0, "en_handshake_while_off");
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      rst        = 1'b0;
      count      = 8'd0;
      pwm_en     = 1'b0;
      duty_data  = 8'd0;
      duty_valid = 1'b0;
      #2;
      test_reset();
      test_duty_load();
      test_boundaries();
      test_wrap_collision();
      test_counter_reset();
      test_async_reset();
      test_enable();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
